pixel_prefetch_fifo: RTL

- Sits between the llhdmi timing generator and the PanoCore shader.
- Generates the shader's pixel-request stream (centred x/y, req, eol, eof, vsync) ahead of display, and buffers shader results in a credit-controlled FWFT FIFO.
- Hands RGB to llhdmi on each display read strobe, decoupling display timing from shader pipeline latency.
- Replaces the free-running hcount/vcount glue with latency-tolerant flow control.

---
 rtl/pixel_prefetch_fifo_if.sv | 39 +++
 rtl/pixel_prefetch_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_prefetch_fifo_if.sv
// -----------------------------------------------------------------------------
// pixel_prefetch_fifo_if
// Request/return bus between the pixel prefetcher and the PanoCore shader.
//
// Request side (prefetcher -> shader):
//   pix_x      12  two's-complement shader column, valid only with req
//   pix_y      11  two's-complement shader row, valid only with req
//   req         1  pixel request valid
//   eol         1  request is the last column of a line
//   eof         1  request is the last pixel of the frame
//   vsync       1  request is pixel (0,0)
// Return side (shader -> prefetcher):
//   pix_valid   1  shader result valid
//   pix_r/g/b   8  shader result colour
//
// Modports: master = prefetcher, slave = shader.
// -----------------------------------------------------------------------------
interface pixel_prefetch_fifo_if;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        req;
    logic        eol;
    logic        eof;
    logic        vsync;
    logic        pix_valid;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;

    modport master (
        output pix_x, pix_y, req, eol, eof, vsync,
        input  pix_valid, pix_r, pix_g, pix_b
    );

    modport slave (
        input  pix_x, pix_y, req, eol, eof, vsync,
        output pix_valid, pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/pixel_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// pixel_prefetch_fifo
// Issues the shader's pixel-request stream ahead of display and buffers the
// shader results in a first-word-fall-through FIFO. A request is only issued
// while (results in flight + results buffered) < DEPTH, so the FIFO can never
// overflow no matter how long the shader pipeline is.
//
// Ports:
//   i_pixclk          pixel clock
//   reset             synchronous, active-high
//   i_newframe        display frame-start pulse: flushes and restarts the frame
//   i_rd              display read strobe: pops the FIFO head
//   o_red/grn/blu     FIFO head, or FILL_RGB when the FIFO is empty
//   shader            request/return bus to the shader (master side)
//   o_underflow       sticky: a read arrived while the FIFO was empty
//   o_underflow_cnt   saturating count of such reads
// -----------------------------------------------------------------------------
module pixel_prefetch_fifo #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          X_OFFSET = 320,
    parameter int          Y_OFFSET = 240,
    parameter int          DEPTH    = 16,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic                        i_pixclk,
    input  logic                        reset,
    input  logic                        i_newframe,
    input  logic                        i_rd,
    output logic [7:0]                  o_red,
    output logic [7:0]                  o_grn,
    output logic [7:0]                  o_blu,
    pixel_prefetch_fifo_if.master       shader,
    output logic                        o_underflow,
    output logic [15:0]                 o_underflow_cnt
);

    localparam int COL_W = $clog2(H_ACTIVE);
    localparam int ROW_W = $clog2(V_ACTIVE);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic [CNT_W-1:0]   inflight_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [23:0]        mem_r [DEPTH];
    logic               underflow_r;
    logic [15:0]        underflow_cnt_r;

    logic               credit_s;
    logic               issue_s;
    logic               at_eol_s;
    logic               at_eof_s;
    logic               ret_s;
    logic               push_s;
    logic               pop_s;
    logic               under_s;
    logic [23:0]        head_s;

    // Credits cover both outstanding shader work and buffered results.
    assign credit_s = ({1'b0, inflight_r} + {1'b0, count_r}) < CREDITS;
    assign at_eol_s = (col_r == COL_LAST);
    assign at_eof_s = at_eol_s && (row_r == ROW_LAST);

    // A result only counts when something is actually outstanding; strays
    // (e.g. from before a reset) are dropped.
    assign ret_s   = shader.pix_valid && (inflight_r != CNT_W'(0));
    // Results are kept only while a frame is live; FLUSH and the frame-start
    // cycle itself throw them away.
    assign push_s  = ret_s && ((state_r == ST_RUN) || (state_r == ST_DONE)) && !i_newframe;
    assign pop_s   = i_rd && (count_r != CNT_W'(0)) && !i_newframe;
    assign under_s = i_rd && (count_r == CNT_W'(0)) && !i_newframe;

    // State register.
    always_ff @(posedge i_pixclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_newframe) state_s = ST_RUN;
                else            state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (i_newframe)              state_s = ST_FLUSH;
                else if (issue_s && at_eof_s) state_s = ST_DONE;
                else                         state_s = ST_RUN;
            end
            ST_DONE: begin
                if (i_newframe) state_s = ST_FLUSH;
                else            state_s = ST_DONE;
            end
            ST_FLUSH: begin
                // col/row were already rewound by i_newframe, so the new
                // frame begins at (0,0) as soon as the old work has drained.
                if (inflight_r == CNT_W'(0)) state_s = ST_RUN;
                else                         state_s = ST_FLUSH;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: requests flow only in RUN and only while a credit is free.
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            ST_RUN:  issue_s = credit_s;
            default: issue_s = 1'b0;
        endcase
    end

    assign shader.req   = issue_s;
    assign shader.eol   = issue_s && at_eol_s;
    assign shader.eof   = issue_s && at_eof_s;
    assign shader.vsync = issue_s && (col_r == COL_W'(0)) && (row_r == ROW_W'(0));
    // Centred coordinates, wrapped to the port width.
    assign shader.pix_x = 12'(int'(col_r) - X_OFFSET);
    assign shader.pix_y = 11'(Y_OFFSET - int'(row_r));

    // Raster position of the next request.
    always_ff @(posedge i_pixclk) begin
        if (reset) begin
            col_r <= COL_W'(0);
            row_r <= ROW_W'(0);
        end else if (i_newframe) begin
            col_r <= COL_W'(0);
            row_r <= ROW_W'(0);
        end else if (issue_s) begin
            if (at_eol_s) begin
                col_r <= COL_W'(0);
                if (row_r == ROW_LAST) row_r <= ROW_W'(0);
                else                   row_r <= row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Outstanding shader requests; survives i_newframe so FLUSH can drain it.
    always_ff @(posedge i_pixclk) begin
        if (reset) begin
            inflight_r <= CNT_W'(0);
        end else begin
            case ({issue_s, ret_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge i_pixclk) begin
        if (reset || i_newframe) begin
            count_r  <= CNT_W'(0);
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            else        rd_ptr_r <= rd_ptr_r;
        end
    end

    // FIFO storage.
    always_ff @(posedge i_pixclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {shader.pix_r, shader.pix_g, shader.pix_b};
        end
    end

    // First-word-fall-through head, with fill colour when nothing is buffered.
    always_comb begin
        head_s = FILL_RGB;
        if (count_r != CNT_W'(0)) head_s = mem_r[rd_ptr_r];
        else                      head_s = FILL_RGB;
    end

    assign o_red = head_s[23:16];
    assign o_grn = head_s[15:8];
    assign o_blu = head_s[7:0];

    // Underflow flag and saturating counter, cleared only by reset.
    always_ff @(posedge i_pixclk) begin
        if (reset) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 16'd0;
        end else if (under_s) begin
            underflow_r <= 1'b1;
            if (underflow_cnt_r != 16'hFFFF) underflow_cnt_r <= underflow_cnt_r + 16'd1;
            else                             underflow_cnt_r <= underflow_cnt_r;
        end else begin
            underflow_r     <= underflow_r;
            underflow_cnt_r <= underflow_cnt_r;
        end
    end

    assign o_underflow     = underflow_r;
    assign o_underflow_cnt = underflow_cnt_r;

endmodule
